// File: rtl/vscale_wb_arbiter.sv
// Register-file write-back arbiter: the pipeline port (A) has priority, and multi-cycle
// results (B) queue in a 2-entry FIFO. Starvation of the FIFO head is relieved by a one-cycle wb_stall.
module vscale_wb_arbiter #(
   parameter int XPR_LEN        = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int STARVE_LIMIT   = 3
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      a_valid,
   input  logic [REG_ADDR_WIDTH-1:0] a_waddr,
   input  logic [XPR_LEN-1:0]        a_wdata,
   input  logic                      b_valid,
   output logic                      b_ready,
   input  logic [REG_ADDR_WIDTH-1:0] b_waddr,
   input  logic [XPR_LEN-1:0]        b_wdata,
   output logic                      wb_stall,
   input  logic [REG_ADDR_WIDTH-1:0] qa1,
   input  logic [REG_ADDR_WIDTH-1:0] qa2,
   output logic                      q_pend1,
   output logic                      q_pend2,
   output logic                      wen,
   output logic [REG_ADDR_WIDTH-1:0] wa,
   output logic [XPR_LEN-1:0]        wd
);

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] addr;
      logic [XPR_LEN-1:0]        data;
   } wb_req_t;

   wb_req_t          fifo_q [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       count;
   logic [CNT_W-1:0] starve_cnt;
   logic             out_b;

   logic             push;
   logic             grant_a;
   logic             grant_b;
   wb_req_t          head;
   wb_req_t          tail;
   wb_req_t          sel;
   logic             head_vld;
   logic             tail_vld;
   logic [CNT_W-1:0] starve_nxt;

   assign b_ready  = reset_n && (count != 2'd2);
   assign push     = b_valid && b_ready;
   assign grant_a  = a_valid;
   assign grant_b  = !a_valid && (count != 2'd0);
   assign head     = fifo_q[rd_ptr];
   assign tail     = fifo_q[~rd_ptr];
   assign head_vld = (count != 2'd0);
   assign tail_vld = (count == 2'd2);
   assign sel      = grant_a ? wb_req_t'{a_waddr, a_wdata} : head;

   // The starvation count only grows while A is bypassing a non-empty FIFO.
   always_comb begin
      // NOTE: default first so every path assigns starve_nxt and no latch is inferred.
      starve_nxt = starve_cnt;
      if (grant_b || count == 2'd0)
         starve_nxt = '0;
      else if (grant_a && starve_cnt != LIMIT)
         starve_nxt = starve_cnt + 1'b1;
   end

   // A register is pending while a B write to it sits in the FIFO or in the output stage.
   assign q_pend1 = reset_n && (qa1 != '0) &&
                    ((head_vld && head.addr == qa1) || (tail_vld && tail.addr == qa1) ||
                     (wen && out_b && wa == qa1));
   assign q_pend2 = reset_n && (qa2 != '0) &&
                    ((head_vld && head.addr == qa2) || (tail_vld && tail.addr == qa2) ||
                     (wen && out_b && wa == qa2));

   // NOTE: FIFO payload storage carries no reset; count/pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push)
         fifo_q[wr_ptr] <= wb_req_t'{b_waddr, b_wdata};
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      if (!reset_n) begin
         count      <= 2'd0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         starve_cnt <= '0;
         wb_stall   <= 1'b0;
         out_b      <= 1'b0;
         wen        <= 1'b0;
         wa         <= '0;
         wd         <= '0;
      end else begin
         if (push)
            wr_ptr <= ~wr_ptr;
         if (grant_b)
            rd_ptr <= ~rd_ptr;
         count      <= count + 2'(push) - 2'(grant_b);
         starve_cnt <= starve_nxt;
         wb_stall   <= (starve_nxt == LIMIT) && !wb_stall;
         out_b      <= grant_b;
         wen        <= (grant_a || grant_b) && (sel.addr != '0);
         if (grant_a || grant_b) begin
            wa <= sel.addr;
            wd <= sel.data;
         end
      end
   end

endmodule

// File: tb/tb_vscale_wb_arbiter.sv
// Directed bench for vscale_wb_arbiter: inputs change 1 ns after the rising edge, and each
// expected value is worked out by hand from the arbitration and FIFO rules.
module tb_vscale_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        a_valid, b_valid;
   logic [4:0]  a_waddr, b_waddr, qa1, qa2, wa;
   logic [31:0] a_wdata, b_wdata, wd;
   logic        b_ready, wb_stall, q_pend1, q_pend2, wen;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vscale_wb_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid(a_valid), .a_waddr(a_waddr), .a_wdata(a_wdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
      .wb_stall(wb_stall), .qa1(qa1), .qa2(qa2), .q_pend1(q_pend1), .q_pend2(q_pend2),
      .wen(wen), .wa(wa), .wd(wd)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; the pipeline must never present A while wb_stall is high.
   task automatic step();
      if (wb_stall === 1'b1 && a_valid === 1'b1)
         check("a_valid_during_stall", 32'(a_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [4:0] addr, input logic [31:0] data);
      a_valid = v; a_waddr = addr; a_wdata = data;
   endtask

   task automatic drive_b(input logic v, input logic [4:0] addr, input logic [31:0] data);
      b_valid = v; b_waddr = addr; b_wdata = data;
   endtask

   initial begin
      reset_n = 1'b0;
      drive_a(1'b1, 5'd3, 32'h1234);
      drive_b(1'b1, 5'd7, 32'h77);
      qa1 = 5'd7; qa2 = 5'd3;

      // Reset: inputs are ignored, outputs cleared.
      step(); step();
      settle();
      check("rst_wen", 32'(wen), 0);
      check("rst_wa", 32'(wa), 0);
      check("rst_wd", wd, 0);
      check("rst_stall", 32'(wb_stall), 0);
      check("rst_b_ready", 32'(b_ready), 0);
      check("rst_q_pend1", 32'(q_pend1), 0);

      reset_n = 1'b1;
      drive_a(1'b0, 5'd0, 32'h0);
      drive_b(1'b0, 5'd0, 32'h0);
      settle();
      check("rel_b_ready", 32'(b_ready), 1);

      // A only.
      drive_a(1'b1, 5'd5, 32'hDEADBEEF);
      settle();
      check("a_b_ready", 32'(b_ready), 1);
      step();
      check("a_wen", 32'(wen), 1);
      check("a_wa", 32'(wa), 5);
      check("a_wd", wd, 32'hDEADBEEF);
      check("a_b_ready2", 32'(b_ready), 1);
      drive_a(1'b0, 5'd0, 32'h0);
      step();
      check("a_idle_wen", 32'(wen), 0);

      // B queuing under continuous A traffic, starvation relief.
      drive_a(1'b1, 5'd1, 32'hA1);
      drive_b(1'b1, 5'd7, 32'h11);
      step();
      drive_a(1'b1, 5'd2, 32'hA2);
      drive_b(1'b1, 5'd8, 32'h22);
      settle();
      check("q_b_ready_c1", 32'(b_ready), 1);
      step();
      drive_a(1'b1, 5'd3, 32'hA3);
      drive_b(1'b0, 5'd0, 32'h0);
      qa1 = 5'd7; qa2 = 5'd8;
      settle();
      check("q_b_ready_full", 32'(b_ready), 0);
      check("q_pend_x7", 32'(q_pend1), 1);
      check("q_pend_x8", 32'(q_pend2), 1);
      check("q_a2_wa", 32'(wa), 2);
      step();
      drive_a(1'b1, 5'd4, 32'hA4);
      check("q_no_stall_yet", 32'(wb_stall), 0);
      step();
      check("q_stall", 32'(wb_stall), 1);
      check("q_a4_wa", 32'(wa), 4);
      check("q_pend_x7_stall", 32'(q_pend1), 1);
      drive_a(1'b0, 5'd0, 32'h0);
      step();
      check("q_x7_wen", 32'(wen), 1);
      check("q_x7_wa", 32'(wa), 7);
      check("q_x7_wd", wd, 32'h11);
      check("q_stall_one_cycle", 32'(wb_stall), 0);
      step();
      check("q_x8_wa", 32'(wa), 8);
      check("q_x8_wd", wd, 32'h22);
      check("q_pend_x8_out", 32'(q_pend2), 1);
      step();
      check("q_drain_wen", 32'(wen), 0);
      check("q_pend_x8_clear", 32'(q_pend2), 0);

      // x0 handling.
      drive_b(1'b1, 5'd0, 32'h55);
      qa1 = 5'd0;
      settle();
      check("x0_q_pend_zero", 32'(q_pend1), 0);
      step();
      drive_b(1'b0, 5'd0, 32'h0);
      check("x0_q_pend_queued", 32'(q_pend1), 0);
      step();
      check("x0_b_wen", 32'(wen), 0);
      drive_a(1'b1, 5'd0, 32'h99);
      step();
      check("x0_a_wen", 32'(wen), 0);
      check("x0_b_ready", 32'(b_ready), 1);
      drive_a(1'b0, 5'd0, 32'h0);
      step();

      // Same-register ordering with concurrent push/pop at count 1.
      qa1 = 5'd9;
      drive_b(1'b1, 5'd9, 32'd1);
      settle();
      check("ord_pend_before", 32'(q_pend1), 0);
      step();
      check("ord_pend_queued", 32'(q_pend1), 1);
      drive_b(1'b1, 5'd9, 32'd2);
      step();
      drive_b(1'b0, 5'd0, 32'h0);
      check("ord_w1_wa", 32'(wa), 9);
      check("ord_w1_wd", wd, 32'd1);
      check("ord_w1_wen", 32'(wen), 1);
      check("ord_pend_mid", 32'(q_pend1), 1);
      check("ord_b_ready_cnt1", 32'(b_ready), 1);
      step();
      check("ord_w2_wen", 32'(wen), 1);
      check("ord_w2_wd", wd, 32'd2);
      check("ord_pend_out", 32'(q_pend1), 1);
      step();
      check("ord_done_wen", 32'(wen), 0);
      check("ord_pend_clear", 32'(q_pend1), 0);

      // Reset mid-queue discards the queued B results.
      drive_a(1'b1, 5'd1, 32'hB1);
      drive_b(1'b1, 5'd7, 32'h77);
      step();
      drive_a(1'b1, 5'd2, 32'hB2);
      drive_b(1'b1, 5'd8, 32'h88);
      step();
      drive_a(1'b0, 5'd0, 32'h0);
      drive_b(1'b0, 5'd0, 32'h0);
      settle();
      check("rq_full", 32'(b_ready), 0);
      reset_n = 1'b0;
      settle();
      check("rq_b_ready_in_rst", 32'(b_ready), 0);
      step();
      reset_n = 1'b1;
      qa1 = 5'd7; qa2 = 5'd8;
      settle();
      check("rq_wen", 32'(wen), 0);
      check("rq_b_ready", 32'(b_ready), 1);
      check("rq_pend_x7", 32'(q_pend1), 0);
      check("rq_pend_x8", 32'(q_pend2), 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("rq_no_write_%0d", i), 32'(wen), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
